// File: rtl/fetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_buffer_pkg
// Shared types for the fetch -> decode instruction queue.
//   IF_ID_PACKET : one fetched instruction (valid, inst, PC, NPC).
// ---------------------------------------------------------------------------
package fetch_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } IF_ID_PACKET;

endpackage

// File: rtl/fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// fetch_buffer_if
// Bundles the fetch-side and dispatch-side signals of fetch_buffer.
//   squash       : branch redirect, empties the buffer at the next edge
//   in_packet    : fetch group, lane [2] oldest, valid lanes contiguous from [2]
//   dispatch_num : lanes consumed by dispatch this cycle, taken from [2] down
//   out_packet   : the three oldest entries, [2] = head
//   buf_stall    : fewer than three free entries, fetch holds its group
//   entry_count  : current occupancy 0..DEPTH
//   dbg_head/tail: read/write pointers, exposed for observation
// Handshake: a fetch group is taken in full at a posedge only when buf_stall
// is low at that edge; otherwise fetch must keep presenting it. Dispatch
// may only consume lanes that show valid; excess dispatch_num is clamped.
// master = fetch/dispatch side, slave = the buffer.
// ---------------------------------------------------------------------------
interface fetch_buffer_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
);
    import fetch_buffer_pkg::*;

    logic                  squash;
    IF_ID_PACKET [2:0]     in_packet;
    logic [1:0]            dispatch_num;
    IF_ID_PACKET [2:0]     out_packet;
    logic                  buf_stall;
    logic [IDX_W:0]        entry_count;
    logic [IDX_W-1:0]      dbg_head;
    logic [IDX_W-1:0]      dbg_tail;

    modport master (
        output squash, in_packet, dispatch_num,
        input  out_packet, buf_stall, entry_count, dbg_head, dbg_tail
    );

    modport slave (
        input  squash, in_packet, dispatch_num,
        output out_packet, buf_stall, entry_count, dbg_head, dbg_tail
    );

endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Circular instruction queue between fetch and decode/dispatch. Takes up to
// three packets per cycle, shows the three oldest to dispatch, which takes
// 0-3 per cycle. Squash empties the queue.
// Ports:
//   clock : system clock, all state updates on posedge
//   reset : asynchronous active-low reset
//   bus   : fetch_buffer_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    fetch_buffer_if.slave  bus
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] THREE_C = (IDX_W+1)'(3);

    IF_ID_PACKET        r_entries [DEPTH];
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [IDX_W:0]     r_count;

    logic [IDX_W:0]     w_free;
    logic               w_stall;
    logic [1:0]         w_in_valid_n;
    logic [1:0]         w_n_in;
    logic [1:0]         w_out_avail;
    logic [1:0]         w_n_out;

    // Stall is a function of registered occupancy only, so fetch sees no
    // combinational path from its own group or from dispatch.
    assign w_free  = DEPTH_C - r_count;
    assign w_stall = (w_free < THREE_C);

    // Valid lanes are contiguous from [2]; count the leading run.
    always_comb begin
        w_in_valid_n = 2'd0;
        if (bus.in_packet[2].valid) begin
            w_in_valid_n = 2'd1;
            if (bus.in_packet[1].valid) begin
                w_in_valid_n = 2'd2;
                if (bus.in_packet[0].valid) begin
                    w_in_valid_n = 2'd3;
                end
            end
        end
    end

    assign w_n_in      = w_stall ? 2'd0 : w_in_valid_n;
    assign w_out_avail = (r_count >= THREE_C) ? 2'd3 : r_count[1:0];
    // Clamp so an over-eager dispatch never underflows the queue.
    assign w_n_out     = (bus.dispatch_num < w_out_avail) ? bus.dispatch_num : w_out_avail;

    // Output lanes read straight from storage: an entry is visible the
    // cycle after it is written, with no bypass from in_packet.
    always_comb begin
        logic [IDX_W:0] v_off;
        v_off = '0;
        for (int k = 0; k < 3; k++) begin
            v_off = (IDX_W+1)'(2 - k);
            bus.out_packet[k] = '0;
            if (v_off < r_count) begin
                bus.out_packet[k]       = r_entries[r_head + v_off[IDX_W-1:0]];
                bus.out_packet[k].valid = 1'b1;
            end
        end
    end

    // Storage: lane [2] lands at tail, [1] at tail+1, [0] at tail+2; the
    // pointer add wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (!bus.squash) begin
            for (int j = 0; j < 3; j++) begin
                if (2'(j) < w_n_in) begin
                    r_entries[r_tail + IDX_W'(j)] <= bus.in_packet[2-j];
                end
            end
        end
    end

    // Pointers and occupancy; squash wins over any read or write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + IDX_W'(w_n_out);
            r_tail  <= r_tail + IDX_W'(w_n_in);
            r_count <= r_count + (IDX_W+1)'(w_n_in) - (IDX_W+1)'(w_n_out);
        end
    end

    assign bus.buf_stall   = w_stall;
    assign bus.entry_count = r_count;
    assign bus.dbg_head    = r_head;
    assign bus.dbg_tail    = r_tail;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  typedef IF_ID_PACKET [2:0] grp_t;
  typedef struct packed {
    logic [IDX_W:0]   cnt;
    logic             st;
    logic [IDX_W-1:0] hd;
    logic [IDX_W-1:0] tl;
    grp_t             lanes;
  } rec_t;
  localparam int W = $bits(rec_t);

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  fetch_buffer_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model + scoreboard ----------------
  IF_ID_PACKET model_q[$];
  int m_head;
  int m_tail;
  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected visible state before the coming edge, derived from the queue.
  task automatic push_expect();
    rec_t r;
    r.cnt = (IDX_W+1)'(model_q.size());
    r.st  = (DEPTH - model_q.size()) < 3;
    r.hd  = IDX_W'(m_head);
    r.tl  = IDX_W'(m_tail);
    for (int j = 0; j < 3; j++) begin
      r.lanes[2-j] = '0;
      if (j < model_q.size()) begin
        r.lanes[2-j] = model_q[j];
        r.lanes[2-j].valid = 1'b1;
      end
    end
    exp_q.push_back(W'(r));
  endtask

  task automatic model_step(input grp_t grp, input int dn, input logic sq);
    int size;
    int nv;
    int n_in;
    int avail;
    int n_out;
    if (sq) begin
      model_q.delete();
      m_head = 0;
      m_tail = 0;
      return;
    end
    size = model_q.size();
    nv = 0;
    if (grp[2].valid) begin
      nv = 1;
      if (grp[1].valid) begin
        nv = 2;
        if (grp[0].valid) nv = 3;
      end
    end
    n_in  = (DEPTH - size >= 3) ? nv : 0;
    avail = (size < 3) ? size : 3;
    n_out = (dn < avail) ? dn : avail;
    for (int i = 0; i < n_out; i++) void'(model_q.pop_front());
    for (int j = 0; j < n_in; j++) model_q.push_back(grp[2-j]);
    m_head = (m_head + n_out) % DEPTH;
    m_tail = (m_tail + n_in) % DEPTH;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input grp_t grp, input int dn, input logic sq);
    @(negedge clock);
    bus.in_packet    = grp;
    bus.dispatch_num = 2'(dn);
    bus.squash       = sq;
    push_expect();
    model_step(grp, dn, sq);
  endtask

  function automatic IF_ID_PACKET mk(input logic [31:0] inst, input logic [31:0] pc);
    IF_ID_PACKET p;
    p.valid = 1'b1;
    p.inst  = inst;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  int next_pc;

  function automatic grp_t mk_grp(input int n, input int base);
    grp_t g;
    for (int j = 0; j < 3; j++) begin
      g[2-j] = mk($urandom(), 32'(base + 4*j));
      g[2-j].valid = (j < n);
    end
    return g;
  endfunction

  task automatic write_n(input int n, input int dn);
    drive_cycle(mk_grp(n, next_pc), dn, 1'b0);
    next_pc += 12;
  endtask

  task automatic idle(input int dn);
    drive_cycle('0, dn, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_count"}, 128'(bus.entry_count), 128'(0));
    check({tag, "_stall"}, 128'(bus.buf_stall), 128'(0));
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_lane%0d", tag, k), 128'(bus.out_packet[k]), 128'(0));
  endtask

  // ---------------- monitor ----------------
  initial begin
    rec_t r;
    forever begin
      @(negedge clock);
      #4;
      if (exp_q.size() > 0) begin
        r = rec_t'(exp_q.pop_front());
        check("count", 128'(bus.entry_count), 128'(r.cnt));
        check("stall", 128'(bus.buf_stall), 128'(r.st));
        check("head", 128'(bus.dbg_head), 128'(r.hd));
        check("tail", 128'(bus.dbg_tail), 128'(r.tl));
        for (int k = 0; k < 3; k++)
          check($sformatf("lane%0d", k), 128'(bus.out_packet[k]), 128'(r.lanes[k]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    grp_t g;
    total = 0;
    bad = 0;
    m_head = 0;
    m_tail = 0;
    next_pc = 32'h100;
    reset = 1'b0;
    bus.squash = 1'b0;
    bus.in_packet = '0;
    bus.dispatch_num = 2'd0;

    // Reset then idle
    repeat (2) @(posedge clock);
    #2;
    check_cleared("reset");
    @(negedge clock);
    #1 reset = 1'b1;
    idle(0);
    idle(3);

    // Single write and read
    g[2] = mk(32'h12345678, 32'd0);
    g[1] = mk(32'habcdef01, 32'd4);
    g[0] = mk(32'h00000013, 32'd8);
    drive_cycle(g, 0, 1'b0);
    idle(2);
    idle(0);

    // Fill to stall, then release by one dispatch
    idle(1);
    write_n(3, 0);
    write_n(3, 0);
    write_n(3, 0);
    write_n(3, 1);
    write_n(3, 0);
    write_n(3, 0);
    idle(0);

    // Simultaneous read/write across the wrap point
    drive_cycle('0, 0, 1'b1);
    write_n(3, 0);
    write_n(3, 3);
    idle(3);
    write_n(3, 0);
    write_n(3, 3);
    idle(3);
    idle(0);

    // Squash priority over write and read
    drive_cycle('0, 0, 1'b1);
    write_n(3, 0);
    write_n(2, 0);
    drive_cycle(mk_grp(3, 32'h900), 3, 1'b1);
    idle(0);

    // Async reset mid-operation
    write_n(3, 0);
    write_n(1, 0);
    idle(0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_cleared("async_reset");
    model_q.delete();
    m_head = 0;
    m_tail = 0;
    @(negedge clock);
    #1 reset = 1'b1;

    // Over-dispatch
    write_n(1, 0);
    idle(3);
    idle(0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 29) == 0)
        drive_cycle(mk_grp($urandom_range(0, 3), next_pc), $urandom_range(0, 3), 1'b1);
      else if (c % 100 < 50)
        write_n($urandom_range(0, 3), $urandom_range(0, 3));
      else
        write_n($urandom_range(1, 3), $urandom_range(0, 2));
    end
    idle(3);
    idle(3);
    idle(3);
    idle(3);

    @(negedge clock);
    #6;
    check("drain", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between pipeline_fetch and decode/dispatch.
- Accepts up to 3 IF_ID_PACKETs per cycle from fetch and holds them in a circular buffer.
- Presents the 3 oldest entries to dispatch, which consumes 0-3 of them per cycle.
- Provides backpressure to fetch, and a squash that discards all contents on a branch redirect.

Parameters:
- DEPTH, 8, number of packet entries; power of 2, >= 4.
- IDX_W, $clog2(DEPTH), width of the head/tail pointers.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately).
- squash  input  1  branch redirect; discard all entries at the next posedge.
- in_packet  input  IF_ID_PACKET[2:0]  fetch group; lane [2] is oldest; valid bits are contiguous from [2] downward.
- dispatch_num  input  2  number of output lanes consumed this cycle (0-3), taken from [2] downward.
- out_packet  output  IF_ID_PACKET[2:0]  the 3 oldest entries; [2] = head.
- buf_stall  output  1  to fetch: fewer than 3 free entries; fetch must hold its group.
- entry_count  output  IDX_W+1  current occupancy, 0..DEPTH.

Behaviour:
- State: entries[DEPTH], head, tail (IDX_W bits, wrap modulo DEPTH), count (IDX_W+1 bits). No other FSM; occupancy drives all behaviour.
- Reset (reset==0, asynchronous):
  - head=tail=count=0; entry valid bits cleared.
  - Outputs: out_packet all lanes zero including valid; buf_stall=0; entry_count=0.
  - Reset mid-operation drops all entries with no partial state.
- n_in:
  - Equals the number of valid in_packet lanes (0-3) when buf_stall==0.
  - Forced to 0 when buf_stall==1; the input group is ignored and fetch re-presents it.
- Write: lane [2] goes to entries[tail], [1] to tail+1, [0] to tail+2, all mod DEPTH. tail' = tail + n_in.
- n_out = min(dispatch_num, number of valid out_packet lanes). A dispatch_num beyond the valid lanes is clamped, never underflows.
- Read: head' = head + n_out.
- count' = count + n_in - n_out.
  - Simultaneous read and write in one cycle is legal.
  - Space and stall use the pre-update count; freed slots are not reusable the same cycle.
- buf_stall = (DEPTH - count) < 3. It is combinational from registered count, so it has no combinational path from in_packet or dispatch_num.
- out_packet lane k (k=2,1,0):
  - Equals entries[head + (2-k)] with valid=1 when (2-k) < count.
  - Otherwise all fields are 0.
  - Combinational from registers, so there is zero-cycle latency from entry to visibility.
  - A packet written at edge t is visible after edge t and dispatchable in cycle t+1. There is no bypass from in_packet to out_packet.
- Squash (sampled at posedge):
  - head=tail=count=0.
  - This cycle's in_packet and dispatch_num are both ignored.
  - Squash has priority over write and read. After the edge, out_packet is all invalid.
- Full: count==DEPTH implies buf_stall=1, and no write occurs.
- Empty: count==0 implies all out lanes invalid; dispatch_num is ignored.
- Wrap-around: a 3-lane write or read spanning index DEPTH-1 to 0 must split correctly.
- PC, NPC and inst are passed through unmodified.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 2 cycles, release, apply no input.
  - Required: entry_count=0, buf_stall=0, all out_packet.valid=0.
- Single write and read:
  - Stimulus: in_packet of 3 valid lanes, inst {12345678, abcdef01, 00000013}, PC {0, 4, 8}, dispatch_num=0.
  - Required, next cycle: out_packet[2].PC=0, [1].PC=4, [0].PC=8; entry_count=3.
  - Stimulus: then dispatch_num=2.
  - Required: entry_count=1, out_packet[2].PC=8, lanes [1] and [0] invalid.
- Fill to stall:
  - Stimulus: write 3, 3 with dispatch_num=0 (count=6).
  - Required: buf_stall=1. A further group is not written (count stays 6).
  - Stimulus: dispatch_num=1.
  - Required: count=5 but buf_stall remains 1 at that edge's input; the next group is accepted once count<=5.
- Simultaneous read and write with wrap:
  - Stimulus: advance head/tail to 6; write 3 while dispatching 3 from count=3.
  - Required: count stays 3, tail=1, out order correct across index 7 to 0.
- Squash priority:
  - Stimulus: count=5, squash=1 together with a valid 3-lane input and dispatch_num=3.
  - Required, next cycle: count=0, all out lanes invalid, buf_stall=0.
- Async reset mid-operation:
  - Stimulus: count=4, drop reset to 0 between clock edges.
  - Required: entry_count=0 and outputs invalid immediately, without a clock edge.
- Over-dispatch:
  - Stimulus: count=1, dispatch_num=3.
  - Required: count=0, no underflow, head advances by 1.
